// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROR, up to STEP positions per clock, IDLE/BUSY handshake.
// Define SHIFT_UNIT_ROTATE_EN to build the rotate datapath; otherwise Mode=11 behaves as SLL.
module shift_unit_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [1:0]         Mode,
  input  logic [WIDTH-1:0]   In,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic [WIDTH-1:0]   Out,
  output logic               Busy,
  output logic               Done
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

  if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("shift_unit_seq: WIDTH must be a power of two >= 8");
  end
  if ((1 << SHAMT_W) != WIDTH) begin : g_bad_shamt_w
    $error("shift_unit_seq: SHAMT_W must equal log2(WIDTH)");
  end
  if (STEP < 1 || STEP > WIDTH / 2 || (STEP & (STEP - 1)) != 0) begin : g_bad_step
    $error("shift_unit_seq: STEP must be a power of two in 1..WIDTH/2");
  end

  state_e             state;
  state_e             state_next;
  mode_e              mode_in;
  mode_e              mode_r;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   work_shifted;
  logic [SHAMT_W-1:0] rem;
  logic [SHAMT_W-1:0] step_k;
  logic               accept;
  logic               finish;

  assign Busy = (state == BUSY);

  // Fold ROR onto SLL at capture time when the rotate datapath is not built.
  always_comb begin
    mode_in = mode_e'(Mode);
`ifndef SHIFT_UNIT_ROTATE_EN
    if (mode_in == MODE_ROR) mode_in = MODE_SLL;
`endif
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (rem == '0) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // One step of at most STEP positions; each candidate is a constant shift selected by step_k.
  always_comb begin
    step_k       = (rem > STEP_AMT) ? STEP_AMT : rem;
    work_shifted = work;
    for (int j = 1; j <= STEP; j++) begin
      if (step_k == SHAMT_W'(j)) begin
        case (mode_r)
          MODE_SRL: work_shifted = work >> j;
          MODE_SRA: work_shifted = $signed(work) >>> j;
`ifdef SHIFT_UNIT_ROTATE_EN
          MODE_ROR: work_shifted = (work >> j) | (work << (WIDTH - j));
`endif
          default:  work_shifted = work << j;
        endcase
      end
    end
  end

  // SRA keeps work's MSB fixed every step, so the fill stays the captured sign bit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      work   <= '0;
      rem    <= '0;
      mode_r <= MODE_SLL;
      Out    <= '0;
      Done   <= 1'b0;
    end else begin
      Done <= finish;
      if (accept) begin
        work   <= In;
        mode_r <= mode_in;
        rem    <= Shamt;
      end else if (Busy && rem != '0) begin
        work <= work_shifted;
        rem  <= rem - step_k;
      end
      if (finish) Out <= work;
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq: directed vector table, hand-written corner
// sequences and randomized single/back-to-back operations against an arithmetic model.
module tb_shift_unit_seq;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int STEP    = 4;

`ifdef SHIFT_UNIT_ROTATE_EN
  localparam logic [31:0] EXP_ROR_3_1  = 32'h8000_0001;
  localparam logic [31:0] EXP_ROR_X_4  = 32'h8123_4567;
`else
  localparam logic [31:0] EXP_ROR_3_1  = 32'h0000_0006;
  localparam logic [31:0] EXP_ROR_X_4  = 32'h2345_6780;
`endif

  logic               Clk = 1'b0;
  logic               Reset;
  logic               Start;
  logic [1:0]         Mode;
  logic [WIDTH-1:0]   In;
  logic [SHAMT_W-1:0] Shamt;
  logic [WIDTH-1:0]   Out;
  logic               Busy;
  logic               Done;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] last_out;

  shift_unit_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .STEP(STEP)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Mode  (Mode),
    .In    (In),
    .Shamt (Shamt),
    .Out   (Out),
    .Busy  (Busy),
    .Done  (Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] a;
    int          s;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: shift semantics from plain arithmetic on the whole operand.
  function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] a, input int s);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    case (m)
      2'b01:   return a >> s;
      2'b10:   return (a >> s) | (a[31] ? ~(ones >> s) : 32'h0);
`ifdef SHIFT_UNIT_ROTATE_EN
      2'b11:   return (s == 0) ? a : ((a >> s) | (a << (32 - s)));
`endif
      default: return a << s;
    endcase
  endfunction

  function automatic int model_lat(input int s);
    return (s + STEP - 1) / STEP + 1;
  endfunction

  // Called at a negedge; returns at the negedge where Done is seen (or the budget runs out).
  task automatic run_op(input string name, input logic [1:0] m, input logic [31:0] a,
                        input int s, input logic [31:0] exp, input int exp_lat);
    int lat;
    Start = 1'b1; Mode = m; In = a; Shamt = SHAMT_W'(s);
    @(negedge Clk);
    Start = 1'b0;
    Mode  = 2'($urandom);
    In    = $urandom;
    Shamt = SHAMT_W'($urandom);
    check({name, "_busy"}, 64'(Busy), 64'(1));
    check({name, "_hold"}, 64'(Out), 64'(last_out));
    lat = 0;
    while (!Done && lat < 64) begin
      @(negedge Clk);
      lat++;
    end
    check({name, "_done"}, 64'(Done), 64'(1));
    check({name, "_out"}, 64'(Out), 64'(exp));
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_idle"}, 64'(Busy), 64'(0));
    last_out = exp;
  endtask

  initial begin
    int cnt;
    int lat_q;
    logic [1:0]  m;
    logic [31:0] a;
    int          s;
    logic [31:0] exp;

    vecs[0] = '{2'b00, 32'h0000_0001,  2, 32'h0000_0004, 2};
    vecs[1] = '{2'b10, 32'h8000_00F0,  8, 32'hFF80_0000, 3};
    vecs[2] = '{2'b01, 32'hFFFF_FFFF, 31, 32'h0000_0001, 9};
    vecs[3] = '{2'b01, 32'h1234_5678,  0, 32'h1234_5678, 1};
    vecs[4] = '{2'b11, 32'h0000_0003,  1, EXP_ROR_3_1,   2};
    vecs[5] = '{2'b00, 32'h8000_0001, 31, 32'h8000_0000, 9};
    vecs[6] = '{2'b10, 32'h7FFF_FFFF, 31, 32'h0000_0000, 9};
    vecs[7] = '{2'b10, 32'h8000_0000, 31, 32'hFFFF_FFFF, 9};
    vecs[8] = '{2'b11, 32'h1234_5678,  4, EXP_ROR_X_4,   2};
    vecs[9] = '{2'b01, 32'hF000_0000, 16, 32'h0000_F000, 5};

    Reset = 1'b1; Start = 1'b1; Mode = 2'b00; In = 32'hDEAD_BEEF; Shamt = 5'd3;
    repeat (3) @(negedge Clk);
    check("rst_out", 64'(Out), 64'(0));
    check("rst_busy", 64'(Busy), 64'(0));
    check("rst_done", 64'(Done), 64'(0));
    last_out = '0;

    // First edge after Reset deasserts accepts; table entries then run back to back.
    Reset = 1'b0;
    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].a, vecs[i].s, vecs[i].exp, vecs[i].lat);

    // Start held into BUSY with different operands is ignored; no extra Done afterwards.
    Start = 1'b1; Mode = 2'b10; In = 32'h8000_00F0; Shamt = 5'd8;
    @(negedge Clk);
    Mode = 2'b00; In = 32'h0000_0001; Shamt = 5'd1;
    @(negedge Clk);
    Start = 1'b0;
    cnt = 1;
    while (!Done && cnt < 64) begin
      @(negedge Clk);
      cnt++;
    end
    check("ign_out", 64'(Out), 64'(32'hFF80_0000));
    check("ign_lat", 64'(cnt), 64'(3));
    last_out = 32'hFF80_0000;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (Done || Busy) cnt++;
    end
    check("ign_quiet", 64'(cnt), 64'(0));
    check("ign_hold", 64'(Out), 64'(last_out));

    // Randomized single operations.
    for (int i = 0; i < 40; i++) begin
      m = 2'($urandom_range(0, 3));
      a = $urandom;
      s = $urandom_range(0, 31);
      run_op($sformatf("rnd%0d", i), m, a, s, model(m, a, s), model_lat(s));
    end

    // Start held high: each accept is the edge ending the Done cycle, so Done-to-Done is latency+1.
    @(negedge Clk);
    m = 2'($urandom_range(0, 3)); a = $urandom; s = $urandom_range(0, 31);
    Start = 1'b1; Mode = m; In = a; Shamt = SHAMT_W'(s);
    for (int i = 0; i < 25; i++) begin
      exp   = model(m, a, s);
      lat_q = model_lat(s);
      cnt   = 0;
      do begin
        @(negedge Clk);
        cnt++;
      end while (!Done && cnt < 64);
      check($sformatf("b2b%0d_gap", i), 64'(cnt), 64'(lat_q + 1));
      check($sformatf("b2b%0d_out", i), 64'(Out), 64'(exp));
      m = 2'($urandom_range(0, 3)); a = $urandom; s = $urandom_range(0, 31);
      Mode = m; In = a; Shamt = SHAMT_W'(s);
    end
    Start = 1'b0;
    @(negedge Clk);
    last_out = exp;
    @(negedge Clk);

    // Reset mid-operation aborts without a Done pulse; a fresh start then completes.
    Start = 1'b1; Mode = 2'b00; In = 32'h0000_00FF; Shamt = 5'd20;
    @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    check("mid_busy", 64'(Busy), 64'(1));
    Reset = 1'b1;
    @(negedge Clk);
    check("mid_rst_out", 64'(Out), 64'(0));
    check("mid_rst_busy", 64'(Busy), 64'(0));
    check("mid_rst_done", 64'(Done), 64'(0));
    Reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (Done) cnt++;
    end
    check("mid_no_done", 64'(cnt), 64'(0));
    last_out = '0;
    run_op("post_rst", 2'b01, 32'hF0F0_0000, 12, 32'h000F_0F00, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
